cnn_layer_sequencer: RTL and testbench
======================================

Name: cnn_layer_sequencer

Overview:
- Parametrised controller that runs a chain of NUM_STAGES CNN layer engines in a fixed order, for example conv1, pool1, conv2, pool2.
- Gives each stage a one-cycle start pulse and waits for that stage's done, then moves to the next stage.
- Measures the cycle count of each stage, guards each stage with a timeout watchdog, supports abort, and captures the final stage's result.
- Sits in top between the global start and the layer engines. It replaces hard-wired per-layer done chaining.

Parameters:
- NUM_STAGES, 4, number of sequenced layer stages (min 1).
- CNT_W, 24, width of the per-stage cycle counter. Must satisfy 2^CNT_W > TIMEOUT.
- TIMEOUT, 1000000, maximum WAIT cycles allowed per stage before a fault.
- RESULT_W, 32, width of the final-stage result.
- IDX_W, derived, max(1, $clog2(NUM_STAGES)).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  request to begin one inference; sampled only in IDLE.
- abort  in  1  cancels a running sequence.
- stage_start  out  NUM_STAGES  one-hot, one-cycle start pulse to stage i.
- stage_done  in  NUM_STAGES  per-stage completion level/pulse.
- result_in  in  RESULT_W  result bus of the last stage.
- busy  out  1  high from LAUNCH through FINISH/FAULT.
- cur_stage  out  IDX_W  index of the active stage.
- stage_cycles  out  CNT_W  cycle count of the most recently completed stage.
- stage_cycles_valid  out  1  one-cycle pulse when stage_cycles updates.
- result  out  RESULT_W  captured final result.
- done  out  1  one-cycle pulse on successful completion.
- error  out  1  sticky timeout flag.
- err_stage  out  IDX_W  index of the stage that timed out.

Behaviour:
- Reset: all outputs 0, FSM to IDLE, internal counter 0. Reset is synchronous, so asserting it mid-sequence returns to IDLE at the next edge. No pulses are emitted in the reset cycle.
- States: IDLE, LAUNCH, WAIT, FINISH, FAULT.
- IDLE:
  - start=1 moves to LAUNCH.
  - cur_stage is set to 0, error and err_stage are cleared, and the counter is cleared.
  - start in any other state is ignored.
- LAUNCH (1 cycle):
  - stage_start[cur_stage]=1, all other bits 0.
  - Counter cleared; go to WAIT.
  - stage_done is not sampled in LAUNCH.
- WAIT:
  - Counter increments each cycle.
  - Only stage_done[cur_stage] is observed. Other bits are ignored.
  - When stage_done[cur_stage]=1 is sampled:
    - stage_cycles = counter+1, i.e. the number of WAIT cycles including this one.
    - stage_cycles_valid pulses the next cycle.
    - If cur_stage < NUM_STAGES-1: increment cur_stage and go to LAUNCH.
    - Otherwise: result <= result_in in this same cycle, then go to FINISH.
- Timeout:
  - If the counter reaches TIMEOUT in WAIT without done, go to FAULT.
  - error <= 1 and err_stage <= cur_stage.
  - stage_done and timeout in the same cycle: done wins.
- FAULT (1 cycle): busy=1, then IDLE. error stays 1 until the next accepted start or rst.
- FINISH (1 cycle): done=1, then IDLE. result holds until the next successful completion or rst.
- Abort:
  - abort=1 in LAUNCH/WAIT/FINISH/FAULT returns to IDLE at the next edge.
  - busy=0 from then on. No done, no stage_cycles_valid, error unchanged.
  - abort has priority over stage_done and timeout in the same cycle.
  - abort in IDLE has no effect. abort and start together in IDLE: start is ignored.
- Latency, each stage done k cycles after its start pulse: stage_start[0] one cycle after start is sampled; each stage occupies k+1 cycles; done asserts 1 + NUM_STAGES*(k+1) cycles after start is sampled.
- busy = (state != IDLE). cur_stage holds its last value in IDLE.

Test Plan:
- Defaults, each stage_done pulses 3 cycles after its stage_start, result_in=32'hDEADBEEF on the last stage's done. Start sampled at cycle 0 -> stage_start pulses at cycles 1, 5, 9, 13; four stage_cycles_valid pulses each with stage_cycles=3; done at cycle 17; result=32'hDEADBEEF; error=0.
- TIMEOUT=50, stage 1 never signals done -> error=1 and err_stage=1 exactly 50 WAIT cycles into stage 1; stage_start[2] never pulses; done stays 0; the next start clears error.
- Start pulsed again during stage 2 -> ignored; pulse sequence and final done cycle identical to scenario 1.
- Abort during stage 2 WAIT -> busy=0 next cycle, no done, error=0; a subsequent start runs the full sequence correctly.
- stage_done[3] held high throughout stage 0 -> no effect on stage 0 timing; stage 0 still reports stage_cycles=3. Stage 3 completes at its first WAIT cycle, giving stage_cycles=1.
- rst asserted mid-WAIT of stage 1 -> all outputs 0 at the next edge, FSM in IDLE; stage_done after reset is ignored until a new start.

Source files
------------

// File: rtl/cnn_layer_sequencer.sv
// cnn_layer_sequencer: runs a fixed chain of CNN layer engines one after
// another. Each stage gets a one-cycle start pulse, is timed while the
// sequencer waits for its done, and is guarded by a timeout watchdog. The
// last stage's result is captured on its completion. A running sequence
// can be cancelled with abort.
module cnn_layer_sequencer #(
  parameter int NUM_STAGES = 4,
  parameter int CNT_W      = 24,
  parameter int TIMEOUT    = 1000000,
  parameter int RESULT_W   = 32,
  parameter int IDX_W      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  output logic [NUM_STAGES-1:0] stage_start,
  input  logic [NUM_STAGES-1:0] stage_done,
  input  logic [RESULT_W-1:0]   result_in,
  output logic                  busy,
  output logic [IDX_W-1:0]      cur_stage,
  output logic [CNT_W-1:0]      stage_cycles,
  output logic                  stage_cycles_valid,
  output logic [RESULT_W-1:0]   result,
  output logic                  done,
  output logic                  error,
  output logic [IDX_W-1:0]      err_stage
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_FINISH = 3'd3;
  localparam logic [2:0] S_FAULT  = 3'd4;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_STAGES - 1);

  logic [2:0]          r_state;
  logic [IDX_W-1:0]    r_cur_stage;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    r_stage_cycles;
  logic                r_stage_cycles_valid;
  logic [RESULT_W-1:0] r_result;
  logic                r_error;
  logic [IDX_W-1:0]    r_err_stage;

  logic [CNT_W-1:0]    w_cnt_next;
  logic                w_done_sel;
  logic                w_timeout;
  logic [NUM_STAGES-1:0] w_stage_start;

  // WAIT-cycle count including the current cycle; only the active stage's done matters.
  assign w_cnt_next = r_cnt + CNT_W'(1);
  assign w_done_sel = stage_done[r_cur_stage];
  assign w_timeout  = (w_cnt_next >= TIMEOUT_C);

  // Sequencer FSM, per-stage cycle counter and captured status/result.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the values from before this edge, independent of statement order.
    r_stage_cycles_valid <= 1'b0;
    if (rst) begin
      r_state              <= S_IDLE;
      r_cur_stage          <= '0;
      r_cnt                <= '0;
      r_stage_cycles       <= '0;
      r_stage_cycles_valid <= 1'b0;
      r_result             <= '0;
      r_error              <= 1'b0;
      r_err_stage          <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          // abort together with start keeps the sequencer idle
          if (start && !abort) begin
            r_state     <= S_LAUNCH;
            r_cur_stage <= '0;
            r_error     <= 1'b0;
            r_err_stage <= '0;
          end
        end
        S_LAUNCH: begin
          r_cnt <= '0;
          if (abort) r_state <= S_IDLE;
          else       r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (abort) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= w_cnt_next;
            // done beats the watchdog when both land in the same cycle
            if (w_done_sel) begin
              r_stage_cycles       <= w_cnt_next;
              r_stage_cycles_valid <= 1'b1;
              if (r_cur_stage == LAST_IDX) begin
                r_result <= result_in;
                r_state  <= S_FINISH;
              end else begin
                r_cur_stage <= r_cur_stage + IDX_W'(1);
                r_state     <= S_LAUNCH;
              end
            end else if (w_timeout) begin
              r_error     <= 1'b1;
              r_err_stage <= r_cur_stage;
              r_state     <= S_FAULT;
            end
          end
        end
        S_FINISH: r_state <= S_IDLE;
        S_FAULT:  r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  // One-hot start pulse to the stage being launched.
  always_comb begin
    // NOTE: default first so no path leaves the vector unassigned (no latch).
    w_stage_start = '0;
    if (r_state == S_LAUNCH && !rst) w_stage_start[r_cur_stage] = 1'b1;
  end

  assign stage_start        = w_stage_start;
  assign busy               = (r_state != S_IDLE);
  assign cur_stage          = r_cur_stage;
  assign stage_cycles       = r_stage_cycles;
  assign stage_cycles_valid = r_stage_cycles_valid && !rst;
  assign result             = r_result;
  assign done               = (r_state == S_FINISH) && !abort && !rst;
  assign error              = r_error;
  assign err_stage          = r_err_stage;

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Bench for cnn_layer_sequencer: behavioural layer engines answer each start
// pulse with a done pulse K cycles later; expected pulses, stage cycle counts
// and final results are queued when a run is started and compared as the
// sequencer produces them.
module tb_cnn_layer_sequencer;

  localparam int NS       = 4;
  localparam int CNT_W    = 24;
  localparam int TIMEOUT  = 50;
  localparam int RESULT_W = 32;
  localparam int IDX_W    = 2;
  localparam int K        = 3;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic                abort = 1'b0;
  logic [NS-1:0]       stage_start;
  logic [NS-1:0]       stage_done;
  logic [RESULT_W-1:0] result_in;
  logic                busy;
  logic [IDX_W-1:0]    cur_stage;
  logic [CNT_W-1:0]    stage_cycles;
  logic                stage_cycles_valid;
  logic [RESULT_W-1:0] result;
  logic                done;
  logic                error;
  logic [IDX_W-1:0]    err_stage;

  logic [NS-1:0]       eng_done = '0;
  logic [NS-1:0]       eng_off = '0;
  logic [NS-1:0]       force_done = '0;
  int                  eng_timer [NS];
  logic [31:0]         run_result = 32'h0;
  int                  cyc = 0;
  int                  n_checks = 0;
  int                  n_errors = 0;

  int q_st_cyc[$];
  int q_st_idx[$];
  int q_v_cyc[$];
  int q_v_val[$];
  int q_d_cyc[$];
  logic [31:0] q_d_res[$];

  assign stage_done = eng_done | force_done;
  assign result_in  = stage_done[NS-1] ? run_result : 32'h0BAD_0BAD;

  cnn_layer_sequencer #(
    .NUM_STAGES(NS), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .RESULT_W(RESULT_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .stage_start(stage_start), .stage_done(stage_done), .result_in(result_in),
    .busy(busy), .cur_stage(cur_stage), .stage_cycles(stage_cycles),
    .stage_cycles_valid(stage_cycles_valid), .result(result), .done(done),
    .error(error), .err_stage(err_stage)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Layer engine models and output scoreboard, evaluated mid-cycle.
  always @(negedge clk) begin : mon
    logic [NS-1:0] nd;
    int t;
    int ec;
    nd = '0;
    for (int i = 0; i < NS; i++) begin
      t = eng_timer[i];
      if (t > 0) begin
        t = t - 1;
        if (t == 0) nd[i] = 1'b1;
      end
      if (stage_start[i] && !eng_off[i]) t = K;
      eng_timer[i] <= t;
    end
    eng_done <= nd;

    if (|stage_start) begin
      if (q_st_cyc.size() == 0) check("unexpected_start", 32'(stage_start), 32'h0);
      else begin
        ec = q_st_cyc.pop_front();
        check("start_cycle", 32'(cyc), 32'(ec));
        check("start_vec", 32'(stage_start), 32'(1) << q_st_idx.pop_front());
      end
    end
    if (stage_cycles_valid) begin
      if (q_v_cyc.size() == 0) check("unexpected_valid", 32'(stage_cycles_valid), 32'h0);
      else begin
        ec = q_v_cyc.pop_front();
        check("valid_cycle", 32'(cyc), 32'(ec));
        check("stage_cycles", 32'(stage_cycles), 32'(q_v_val.pop_front()));
      end
    end
    if (done) begin
      if (q_d_cyc.size() == 0) check("unexpected_done", 32'(done), 32'h0);
      else begin
        ec = q_d_cyc.pop_front();
        check("done_cycle", 32'(cyc), 32'(ec));
        check("done_result", result, q_d_res.pop_front());
        check("done_error", 32'(error), 32'h0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_cycle(input int n);
    while (cyc < n) step();
  endtask

  task automatic sample(input int n);
    at_cycle(n);
    @(negedge clk);
  endtask

  task automatic exp_start(input int c, input int idx);
    q_st_cyc.push_back(c);
    q_st_idx.push_back(idx);
  endtask

  task automatic exp_valid(input int c, input int v);
    q_v_cyc.push_back(c);
    q_v_val.push_back(v);
  endtask

  // Queue a complete run; d0..d3 are WAIT cycles per stage.
  task automatic start_full(input int d0, input int d1, input int d2, input int d3,
                            input logic [31:0] res, output int s);
    int d [NS];
    int t;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    step();
    s = cyc;
    t = s + 1;
    for (int i = 0; i < NS; i++) begin
      exp_start(t, i);
      exp_valid(t + d[i] + 1, d[i]);
      t = t + d[i] + 1;
    end
    q_d_cyc.push_back(t);
    q_d_res.push_back(res);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic start_bare(output int s);
    step();
    s = cyc;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic check_empty(input string tag);
    check(tag, 32'(q_st_cyc.size() + q_v_cyc.size() + q_d_cyc.size()), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running expected finish");
    $fatal(1);
  end

  initial begin
    int s;
    for (int i = 0; i < NS; i++) eng_timer[i] = 0;

    // Reset state
    repeat (3) step();
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_stage_start", 32'(stage_start), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_error", 32'(error), 32'h0);
    check("rst_err_stage", 32'(err_stage), 32'h0);
    check("rst_cur_stage", 32'(cur_stage), 32'h0);
    check("rst_stage_cycles", 32'(stage_cycles), 32'h0);
    check("rst_valid", 32'(stage_cycles_valid), 32'h0);
    check("rst_result", result, 32'h0);
    step();
    rst = 1'b0;
    repeat (2) step();

    // Normal four-stage run
    run_result = 32'hDEAD_BEEF;
    start_full(3, 3, 3, 3, 32'hDEAD_BEEF, s);
    sample(s + 17);
    check("s1_busy_finish", 32'(busy), 32'h1);
    sample(s + 18);
    check("s1_busy_after", 32'(busy), 32'h0);
    check("s1_result", result, 32'hDEAD_BEEF);
    check("s1_error", 32'(error), 32'h0);
    check("s1_cur_stage_hold", 32'(cur_stage), 32'h3);
    check_empty("s1_queue_empty");
    repeat (3) step();

    // Second start during stage 2 is ignored
    run_result = 32'h1111_2222;
    start_full(3, 3, 3, 3, 32'h1111_2222, s);
    at_cycle(s + 10);
    start = 1'b1;
    step();
    start = 1'b0;
    sample(s + 18);
    check("s3_busy_after", 32'(busy), 32'h0);
    check("s3_result", result, 32'h1111_2222);
    check_empty("s3_queue_empty");
    repeat (3) step();

    // Stage 1 never completes -> timeout fault
    eng_off = 4'b0010;
    step();
    exp_start(cyc + 2, 0);
    exp_valid(cyc + 6, 3);
    exp_start(cyc + 6, 1);
    start_bare(s);
    sample(s + 55);
    check("to_error_before", 32'(error), 32'h0);
    check("to_busy_wait", 32'(busy), 32'h1);
    check("to_cur_stage", 32'(cur_stage), 32'h1);
    sample(s + 56);
    check("to_error", 32'(error), 32'h1);
    check("to_err_stage", 32'(err_stage), 32'h1);
    check("to_busy_fault", 32'(busy), 32'h1);
    sample(s + 57);
    check("to_busy_idle", 32'(busy), 32'h0);
    sample(s + 60);
    check("to_error_sticky", 32'(error), 32'h1);
    check_empty("to_queue_empty");
    eng_off = '0;
    repeat (3) step();

    // Abort during stage 2 WAIT; start also clears the sticky error
    step();
    exp_start(cyc + 2, 0);
    exp_valid(cyc + 6, 3);
    exp_start(cyc + 6, 1);
    exp_valid(cyc + 10, 3);
    exp_start(cyc + 10, 2);
    start_bare(s);
    sample(s + 1);
    check("ab_error_cleared", 32'(error), 32'h0);
    check("ab_err_stage_cleared", 32'(err_stage), 32'h0);
    at_cycle(s + 11);
    abort = 1'b1;
    sample(s + 11);
    check("ab_busy_during", 32'(busy), 32'h1);
    step();
    abort = 1'b0;
    sample(s + 12);
    check("ab_busy_after", 32'(busy), 32'h0);
    check("ab_error", 32'(error), 32'h0);
    sample(s + 15);
    check("ab_still_idle", 32'(busy), 32'h0);
    check_empty("ab_queue_empty");

    run_result = 32'hCAFE_F00D;
    start_full(3, 3, 3, 3, 32'hCAFE_F00D, s);
    sample(s + 18);
    check("ab_rerun_result", result, 32'hCAFE_F00D);
    check("ab_rerun_busy", 32'(busy), 32'h0);
    check_empty("ab_rerun_queue_empty");
    repeat (3) step();

    // stage_done[3] held high from the start of the run
    force_done = 4'b1000;
    run_result = 32'h5A5A_A5A5;
    start_full(3, 3, 3, 1, 32'h5A5A_A5A5, s);
    sample(s + 16);
    check("fd_busy_after", 32'(busy), 32'h0);
    check("fd_result", result, 32'h5A5A_A5A5);
    step();
    force_done = '0;
    at_cycle(s + 21);
    check_empty("fd_queue_empty");

    // Synchronous reset in the middle of stage 1 WAIT
    step();
    exp_start(cyc + 2, 0);
    exp_valid(cyc + 6, 3);
    exp_start(cyc + 6, 1);
    start_bare(s);
    at_cycle(s + 7);
    rst = 1'b1;
    step();
    rst = 1'b0;
    sample(s + 8);
    check("mr_busy", 32'(busy), 32'h0);
    check("mr_result", result, 32'h0);
    check("mr_cur_stage", 32'(cur_stage), 32'h0);
    check("mr_stage_cycles", 32'(stage_cycles), 32'h0);
    check("mr_error", 32'(error), 32'h0);
    sample(s + 11);
    check("mr_busy_ignores_done", 32'(busy), 32'h0);
    check_empty("mr_queue_empty");

    // abort together with start in IDLE: start ignored
    step();
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check("as_busy", 32'(busy), 32'h0);
    repeat (3) step();
    check("as_busy_later", 32'(busy), 32'h0);
    check_empty("final_queue_empty");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
